// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, HI/LO write and result signals of the multiply/divide unit.
`timescale 1ns/1ps
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    modport master (output start, op, operand_a, operand_b, hi_wr, lo_wr, wr_data,
                    input hi, lo, busy, done);
    modport slave (input start, op, operand_a, operand_b, hi_wr, lo_wr, wr_data,
                   output hi, lo, busy, done);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle on magnitudes,
// signs applied in a final FINISH cycle.
`timescale 1ns/1ps
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic            clock,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);
    logic [1:0]         state_q, state_d;
    logic               div_q, div_d, sp_q, sp_d, sr_q, sr_d, dz_q, dz_d, done_q, done_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH:0]     rem_q, rem_d, msum;
    logic [WIDTH+1:0]   shifted, diff;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, rem_res, quo;
    assign sa      = ~bus.op[0] & bus.operand_a[WIDTH-1];
    assign sb      = ~bus.op[0] & bus.operand_b[WIDTH-1];
    assign mag_a   = sa ? -bus.operand_a : bus.operand_a;
    assign mag_b   = sb ? -bus.operand_b : bus.operand_b;
    // acc_q: multiply = {partial product, remaining multiplier}; divide = dividend/quotient in low half
    assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign diff    = shifted - {2'b00, b_q};
    assign prod    = sp_q ? -acc_q : acc_q;
    assign quo     = dz_q ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
    assign rem_res = sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sp_d    = sp_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            hi_d = bus.hi_wr ? bus.wr_data : hi_q;
            lo_d = bus.lo_wr ? bus.wr_data : lo_q;
            if (bus.start) begin
                state_d = RUN;
                div_d   = bus.op[1];
                sp_d    = sa ^ sb;
                sr_d    = sa;
                dz_d    = bus.op[1] & (bus.operand_b == '0);
                a_d     = mag_a;
                b_d     = mag_b;
                acc_d   = {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
                rem_d   = '0;
                cnt_d   = CW'(WIDTH);
            end
        end else if (state_q == RUN) begin
            cnt_d   = cnt_q - CW'(1);
            acc_d   = div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH+1]}
                            : {msum, acc_q[WIDTH-1:1]};
            rem_d   = div_q ? (diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0]) : rem_q;
            state_d = (cnt_q == CW'(1)) ? FINISH : RUN;
        end else begin
            hi_d    = div_q ? rem_res : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? quo : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            sp_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sp_q    <= sp_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed HI/LO results.
`timescale 1ns/1ps
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Called one negedge after the start edge; counts busy cycles until done, bounded.
    task automatic wait_done(input string tag, input int exp_lat);
        int nb;
        nb = 0;
        while (!bus.done && nb < 100) begin
            if (bus.busy) nb++;
            @(negedge clock);
        end
        check({tag, "_lat"}, nb, exp_lat);
        check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 0);
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 0);
        check({tag, "_idle"}, {31'b0, bus.busy}, 0);
    endtask
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        bus.start = 1'b1;
        bus.op = o;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(tag, 33);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int ndone;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done", {31'b0, bus.done}, 0);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        // MULTU 6*7 with a second start and an mthi injected at cycle 10
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.operand_a = 32'd6;
        bus.operand_b = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
        bus.hi_wr = 1'b1;
        bus.wr_data = 32'hDEADBEEF;
        @(negedge clock);
        bus.start = 1'b0;
        bus.hi_wr = 1'b0;
        check("busy_hi_hold", bus.hi, 32'h00000000);
        check("busy_lo_hold", bus.lo, 32'h80000000);
        wait_done("ignore", 23);
        check("ignore_hi", bus.hi, 32'd0);
        check("ignore_lo", bus.lo, 32'd42);
        // DIV aborted by reset at cycle 15
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", {31'b0, bus.busy}, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) ndone++;
            @(negedge clock);
        end
        check("abort_no_done", ndone, 0);
        bus.lo_wr = 1'b1;
        bus.wr_data = 32'hA5A5A5A5;
        @(negedge clock);
        bus.lo_wr = 1'b0;
        check("mtlo_lo", bus.lo, 32'hA5A5A5A5);
        check("mtlo_hi", bus.hi, 0);
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.wr_data = 32'h13579BDF;
        @(negedge clock);
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        check("mthilo_hi", bus.hi, 32'h13579BDF);
        check("mthilo_lo", bus.lo, 32'h13579BDF);
        // mthi on the start edge lands, then the result overwrites it
        bus.hi_wr = 1'b1;
        bus.wr_data = 32'hCAFEF00D;
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.operand_a = 32'd50;
        bus.operand_b = 32'd8;
        @(negedge clock);
        bus.start = 1'b0;
        bus.hi_wr = 1'b0;
        check("wr_start_hi", bus.hi, 32'hCAFEF00D);
        wait_done("wr_start", 33);
        check("wr_start_res_hi", bus.hi, 32'd2);
        check("wr_start_res_lo", bus.lo, 32'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
